cordic_sin_scheduler: RTL and testbench

Shares one iterative CORDIC sine core among `NREQ` requesters. Each requester presents a Q2.28 angle on a valid/ready port. The scheduler grants requesters round-robin, sequences the core with a start/done handshake, guards each run with a watchdog, and returns a result tagged with the requester ID on a single valid/ready response port. It sits between client datapaths and `cordic_sin_core`.

---
 rtl/cordic_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/cordic_sin_scheduler.sv | 115 +++++++++++
 tb/tb_cordic_sin_scheduler.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sine scheduler slice.
// Q2.28 angle/sine width, scheduler states and reference angles.
package cordic_pkg;

  localparam int DATA_WIDTH = 30;

  typedef logic signed [DATA_WIDTH-1:0] angle_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam angle_t PI_OVER_6 = 30'h0860A91C;
  localparam angle_t HALF      = 30'h08000000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_sin_scheduler.sv
// Round-robin sharing of one iterative CORDIC sine core among NREQ
// requesters, with a watchdog on every core run.
module cordic_sin_scheduler #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = cordic_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = 32,
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*DATA_WIDTH-1:0] req_angle,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_WIDTH-1:0]      rsp_sin,
  output logic                       rsp_err,
  output logic                       core_start,
  output logic [DATA_WIDTH-1:0]      core_z,
  input  logic                       core_done,
  input  logic [DATA_WIDTH-1:0]      core_sin,
  output logic                       busy
);

  import cordic_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                  state;
  logic [ID_W-1:0]         rr_ptr;
  logic [NREQ-1:0]         grant;
  logic [ID_W-1:0]         grant_id;
  logic                    any;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    expired;
  logic [DATA_WIDTH-1:0]   sel_angle;

  rr_arbiter #(
    .NREQ(NREQ),
    .ID_W(ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .grant_id(grant_id),
    .any     (any)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign sel_angle = req_angle[grant_id * DATA_WIDTH +: DATA_WIDTH];

  // Saturating watchdog; expiry is judged on the incremented value.
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign expired = cnt_inc >= CNT_W'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sin    <= '0;
      rsp_err    <= 1'b0;
      core_start <= 1'b0;
      core_z     <= '0;
      busy       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            core_z     <= sel_angle;
            rsp_id     <= grant_id;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done in the expiry cycle still delivers its result.
          if (core_done) begin
            rsp_sin   <= core_sin;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (expired) begin
            rsp_sin   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= rsp_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sin_scheduler.sv
// Bench for cordic_sin_scheduler: directed timing cases plus a random
// run against a transaction-level scheduler/core model.
module tb_cordic_sin_scheduler;
  import cordic_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 30;
  localparam int TO   = 32;
  localparam int ID_W = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_angle;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [DW-1:0]        rsp_sin;
  logic                 rsp_err;
  logic                 core_start;
  logic [DW-1:0]        core_z;
  logic                 core_done;
  logic [DW-1:0]        core_sin;
  logic                 busy;

  always #5 clk = ~clk;

  cordic_sin_scheduler #(
    .NREQ(NREQ),
    .DATA_WIDTH(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_angle(req_angle),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_sin(rsp_sin),
    .rsp_err(rsp_err),
    .core_start(core_start),
    .core_z(core_z),
    .core_done(core_done),
    .core_sin(core_sin),
    .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Core model: sin(pi/6) = 1/2, any other angle maps to a tagged value.
  function automatic logic [DW-1:0] fsin(input logic [DW-1:0] z);
    logic [DW-1:0] p6;
    p6 = PI_OVER_6;
    if (z == p6) return HALF;
    return z ^ 30'h2AAAAAAA;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] x;
    x = '0;
    x[i] = 1'b1;
    return x;
  endfunction

  function automatic int winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  int            rem = 0;
  int            lat = 11;
  int            job_lat = 0;
  bit            dead = 0;
  bit            inject = 0;
  logic [DW-1:0] zlat = '0;

  // One cycle: go to the falling edge, update the core model, settle.
  task automatic cyc();
    @(negedge clk);
    core_done = inject;
    inject = 0;
    if (rst) begin
      rem = 0;
      core_done = 1'b0;
    end else begin
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          core_done = 1'b1;
          core_sin = fsin(zlat);
        end
      end
      if (core_start) begin
        zlat = core_z;
        job_lat = lat;
        rem = dead ? 0 : lat;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_angle = '0;
    inject = 0;
    dead = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_angle(input int i, input logic [DW-1:0] a);
    req_angle[i*DW +: DW] = a;
  endtask

  // Cycles after the accept edge until rsp_valid; 1 = the ISSUE cycle.
  task automatic wait_rsp(input string tag, input int limit, output int k);
    k = 1;
    while (!rsp_valid && k < limit) begin
      cyc();
      k++;
    end
    if (!rsp_valid) check({tag, "_no_rsp"}, 0, 1);
  endtask

  logic [DW-1:0] a;
  int            k;
  int            bad;
  int            bad2;
  int            starts;
  int            g[$];
  logic [ID_W-1:0] id0;
  logic [DW-1:0] sin0;

  // Random-phase model state
  logic [NREQ-1:0] pend;
  logic [DW-1:0]   ang [NREQ];
  int              m_ptr;
  bit              inflight;
  int              exp_id;
  logic [DW-1:0]   exp_ang;
  bit              acc_pending;
  int              acc_id;
  bit              hold;
  logic [33:0]     hold_val;
  int              jobs;
  int              w;
  logic [NREQ-1:0] exp_ready;
  bit              exp_err;

  initial begin
    core_done = 1'b0;
    core_sin = '0;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_angle = '0;
    cyc();
    check("reset_ctl", {req_ready, rsp_valid, rsp_id, rsp_err, core_start, busy}, 0);
    check("reset_data", {rsp_sin, core_z}, 0);
    do_reset();

    // Single request from requester 2
    lat = 11;
    set_angle(2, PI_OVER_6);
    req_valid = 4'b0100;
    #1;
    check("single_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    check("single_start", core_start, 1);
    wait_rsp("single", 60, k);
    check("single_latency", k, 13);
    check("single_id", rsp_id, 2);
    check("single_sin", rsp_sin, HALF);
    check("single_err", rsp_err, 0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check("single_idle", {rsp_valid, busy}, 0);

    // All four held high from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) set_angle(i, DW'($urandom));
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    bad = 0;
    starts = 0;
    g.delete();
    for (int c = 0; c < 200 && g.size() < 5; c++) begin
      if (req_ready != '0) begin
        if ($countones(req_ready) != 1) bad++;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g.push_back(i);
      end
      cyc();
      if (core_start) starts++;
    end
    check("rr_count", g.size(), 5);
    for (int i = 0; i < g.size(); i++) check("rr_order", g[i], i % NREQ);
    check("rr_onehot", bad, 0);
    check("rr_starts", starts, 5);
    req_valid = '0;
    rsp_ready = 1'b0;

    // Backpressure for 20 cycles
    do_reset();
    a = DW'($urandom);
    set_angle(1, a);
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    wait_rsp("bp", 60, k);
    check("bp_id", rsp_id, 1);
    check("bp_sin", rsp_sin, fsin(a));
    id0 = rsp_id;
    sin0 = rsp_sin;
    req_valid = 4'hF;
    bad = 0;
    bad2 = 0;
    repeat (20) begin
      cyc();
      if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_sin !== sin0) bad++;
      if (req_ready != '0 || core_start) bad2++;
    end
    check("bp_hold", bad, 0);
    check("bp_quiet", bad2, 0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check("bp_release", {rsp_valid, busy}, 0);
    check("bp_next_grant", req_ready, 4'b0100);
    req_valid = '0;

    // Watchdog: core never answers, then a stray done is ignored
    do_reset();
    dead = 1;
    set_angle(3, DW'($urandom));
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    wait_rsp("wd", 80, k);
    check("wd_latency", k, TO + 2);
    check("wd_err", rsp_err, 1);
    check("wd_sin", rsp_sin, 0);
    core_sin = 30'h1234567;
    inject = 1;
    cyc();
    cyc();
    check("wd_late_done", {rsp_valid, rsp_err, rsp_sin}, {1'b1, 1'b1, 30'h0});
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    inject = 1;
    cyc();
    cyc();
    check("wd_idle_done", {busy, rsp_valid, core_start}, 0);
    dead = 0;

    // Done in the same cycle the watchdog expires
    do_reset();
    lat = TO;
    a = DW'($urandom);
    set_angle(0, a);
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    wait_rsp("tie", 80, k);
    check("tie_latency", k, TO + 2);
    check("tie_err", rsp_err, 0);
    check("tie_sin", rsp_sin, fsin(a));
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // Reset while waiting on the core
    do_reset();
    lat = 11;
    set_angle(1, DW'($urandom));
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    cyc();
    req_valid = '0;
    wait_rsp("rw_pre", 60, k);
    cyc();
    rsp_ready = 1'b0;
    set_angle(3, DW'($urandom));
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    check("rw_start", core_start, 1);
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    check("rw_ctl", {req_ready, rsp_valid, rsp_id, rsp_err, core_start, busy}, 0);
    check("rw_data", {rsp_sin, core_z}, 0);
    rst = 1'b0;
    bad = 0;
    repeat (15) begin
      cyc();
      if (rsp_valid) bad++;
    end
    check("rw_no_rsp", bad, 0);
    req_valid = 4'hF;
    #1;
    check("rw_grant0", req_ready, 4'b0001);
    req_valid = '0;

    // Random traffic against the transaction model
    do_reset();
    pend = '0;
    m_ptr = 0;
    inflight = 0;
    acc_pending = 0;
    hold = 0;
    jobs = 0;
    for (int c = 0; c < 1800; c++) begin
      cyc();
      if (acc_pending) begin
        pend[acc_id] = 1'b0;
        req_valid[acc_id] = 1'b0;
        acc_pending = 0;
      end
      if (c < 1500) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && $urandom_range(2) == 0) begin
            ang[i] = ($urandom_range(3) == 0) ? PI_OVER_6 : DW'($urandom);
            set_angle(i, ang[i]);
            pend[i] = 1'b1;
            req_valid[i] = 1'b1;
          end
        end
        rsp_ready = ($urandom_range(3) != 0);
      end else begin
        rsp_ready = 1'b1;
      end
      case ($urandom_range(5))
        0: lat = 1;
        1: lat = 11;
        2: lat = TO - 1;
        3: lat = TO;
        4: lat = TO + 1;
        default: lat = $urandom_range(2, 40);
      endcase
      #1;
      if (hold) check("rnd_hold", {rsp_valid, rsp_id, rsp_sin, rsp_err}, hold_val);
      hold = 0;
      w = winner(pend, m_ptr);
      exp_ready = (!inflight && w >= 0) ? onehot(w) : '0;
      check("rnd_ready", req_ready, exp_ready);
      if (exp_ready != '0) begin
        inflight = 1;
        exp_id = w;
        exp_ang = ang[w];
        acc_pending = 1;
        acc_id = w;
      end
      if (rsp_valid && rsp_ready) begin
        check("rnd_expected", inflight, 1);
        exp_err = job_lat > TO;
        check("rnd_id", rsp_id, exp_id);
        check("rnd_err", rsp_err, exp_err);
        check("rnd_sin", rsp_sin, exp_err ? '0 : fsin(exp_ang));
        m_ptr = (exp_id + 1) % NREQ;
        inflight = 0;
        jobs++;
      end else if (rsp_valid) begin
        hold = 1;
        hold_val = {rsp_valid, rsp_id, rsp_sin, rsp_err};
      end
    end
    check("rnd_drained", {inflight, pend}, 0);
    check("rnd_jobs", jobs > 20, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
